dual_rail_rx: RTL and testbench

DUAL_RAIL_RX -- requirements
Module: dual_rail_rx

---
 rtl/dual_rail_rx.sv | 105 ++++++++++
 tb/tb_dual_rail_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_rail_rx.sv
`default_nettype none
// ============================================================================
// Module   : dual_rail_rx
// Brief    : Return-to-zero dual-rail receiver; assembles LSB-first words and
//            counts protocol violations (both rails high).
// Revision : 1.0 - initial release
// ============================================================================
module dual_rail_rx #(
   parameter int WIDTH = 8,
   parameter int ERR_W = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         rail_t,
   input  logic                         rail_f,
   input  logic                         clr_err,
   output logic [WIDTH-1:0]             word_data,
   output logic                         word_valid,
   output logic                         err_pulse,
   output logic [ERR_W-1:0]             err_count,
   output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

   localparam int                 c_CNT_W = $clog2(WIDTH+1);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH-1);

   typedef enum logic [0:0] {
      WAIT_SPACER = 1'b0,
      WAIT_DATA   = 1'b1
   } state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_shift;
   logic [WIDTH-1:0]     r_word_data;
   logic                 r_word_valid;
   logic                 r_err_pulse;
   logic [ERR_W-1:0]     r_err_count;
   logic [c_CNT_W-1:0]   r_bit_cnt;

   logic w_illegal;
   logic w_spacer;
   logic w_bit;

   assign w_illegal = rail_t & rail_f;
   assign w_spacer  = ~rail_t & ~rail_f;
   assign w_bit     = rail_t;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= WAIT_SPACER;
         r_shift      <= '0;
         r_word_data  <= '0;
         r_word_valid <= 1'b0;
         r_err_pulse  <= 1'b0;
         r_err_count  <= '0;
         r_bit_cnt    <= '0;
      end else begin
         r_word_valid <= 1'b0;
         r_err_pulse  <= 1'b0;

         // A clear coinciding with an error leaves exactly that one error counted
         if (clr_err)
            r_err_count <= w_illegal ? ERR_W'(1) : '0;
         else if (w_illegal && (r_err_count != '1))
            r_err_count <= r_err_count + 1'b1;

         if (w_illegal) begin
            r_err_pulse <= 1'b1;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_state     <= WAIT_SPACER;
         end else begin
            case (r_state)
               WAIT_SPACER: begin
                  if (w_spacer)
                     r_state <= WAIT_DATA;
               end
               WAIT_DATA: begin
                  if (!w_spacer) begin
                     r_state <= WAIT_SPACER;
                     if (r_bit_cnt == c_LAST) begin
                        r_word_data  <= {w_bit, r_shift[WIDTH-1:1]};
                        r_word_valid <= 1'b1;
                        r_shift      <= '0;
                        r_bit_cnt    <= '0;
                     end else begin
                        r_shift   <= {w_bit, r_shift[WIDTH-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end
               end
               default: r_state <= WAIT_SPACER;
            endcase
         end
      end
   end

   assign word_data  = r_word_data;
   assign word_valid = r_word_valid;
   assign err_pulse  = r_err_pulse;
   assign err_count  = r_err_count;
   assign bit_cnt    = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dual_rail_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_rail_rx
// Brief    : Randomized bench for dual_rail_rx with a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_rail_rx;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic rail_t = 1'b0;
   logic rail_f = 1'b0;
   logic clr_err = 1'b0;

   logic [7:0] word_data, word_data2;
   logic       word_valid, word_valid2;
   logic       err_pulse, err_pulse2;
   logic [7:0] err_count;
   logic [1:0] err_count2;
   logic [3:0] bit_cnt, bit_cnt2;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit cmp_en = 1'b0;
   int vt[$];
   int vd[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dual_rail_rx dut (
      .clk(clk), .rstn(rstn), .rail_t(rail_t), .rail_f(rail_f), .clr_err(clr_err),
      .word_data(word_data), .word_valid(word_valid), .err_pulse(err_pulse),
      .err_count(err_count), .bit_cnt(bit_cnt)
   );

   dual_rail_rx #(.WIDTH(8), .ERR_W(2)) dut2 (
      .clk(clk), .rstn(rstn), .rail_t(rail_t), .rail_f(rail_f), .clr_err(clr_err),
      .word_data(word_data2), .word_valid(word_valid2), .err_pulse(err_pulse2),
      .err_count(err_count2), .bit_cnt(bit_cnt2)
   );

   // Model: "armed" means a spacer has been seen since the last accepted bit or error
   typedef struct packed {
      logic        armed;
      logic [31:0] nbits;
      logic [31:0] acc;
      logic [7:0]  word;
      logic        valid;
      logic        err;
      logic [31:0] errs;
   } mdl_t;

   mdl_t m = '0;

   function automatic mdl_t step(mdl_t cur, logic t, logic f, logic clr);
      mdl_t n = cur;
      n.valid = 1'b0;
      n.err   = 1'b0;
      if (clr) n.errs = 0;
      if (t && f) begin
         n.err   = 1'b1;
         n.errs  = n.errs + 1;
         n.nbits = 0;
         n.acc   = 0;
         n.armed = 1'b0;
      end else if (!t && !f) begin
         n.armed = 1'b1;
      end else if (cur.armed) begin
         n.armed = 1'b0;
         n.acc   = cur.acc + (t ? (32'd1 << cur.nbits) : 32'd0);
         n.nbits = cur.nbits + 1;
         if (n.nbits == 8) begin
            n.word  = n.acc[7:0];
            n.valid = 1'b1;
            n.nbits = 0;
            n.acc   = 0;
         end
      end
      return n;
   endfunction

   function automatic int sat(logic [31:0] e, int mx);
      return (e > mx) ? mx : int'(e);
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) m <= '0;
      else       m <= step(m, rail_t, rail_f, clr_err);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("word_data",  32'(word_data),  32'(m.word));
         chk("word_valid", 32'(word_valid), 32'(m.valid));
         chk("err_pulse",  32'(err_pulse),  32'(m.err));
         chk("bit_cnt",    32'(bit_cnt),    m.nbits);
         chk("err_count",  32'(err_count),  32'(sat(m.errs, 255)));
         chk("err_count2", 32'(err_count2), 32'(sat(m.errs, 3)));
         chk("word_data2", 32'(word_data2), 32'(m.word));
         if (word_valid) begin
            vt.push_back(cyc);
            vd.push_back(int'(word_data));
         end
      end
   end

   task automatic drive(input logic t, input logic f, input logic clr, input int n);
      repeat (n) begin
         rail_t  = t;
         rail_f  = f;
         clr_err = clr;
         @(negedge clk);
      end
   endtask

   task automatic send_bit(input logic b);
      drive(1'b0, 1'b0, 1'b0, 1);
      drive(b, ~b, 1'b0, 1);
   endtask

   task automatic send_word(input logic [7:0] w, input bit check);
      for (int i = 0; i < 8; i++) send_bit(w[i]);
      if (check) begin
         chk("lit_valid", 32'(word_valid), 32'd1);
         chk("lit_data",  32'(word_data),  32'(w));
         chk("lit_cnt0",  32'(bit_cnt),    32'd0);
      end
   endtask

   initial begin
      int exp5[5];
      exp5 = '{1, 2, 3, 3, 3};

      @(negedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      chk("rst_data",  32'(word_data),  32'd0);
      chk("rst_valid", 32'(word_valid), 32'd0);
      chk("rst_cnt",   32'(bit_cnt),    32'd0);
      chk("rst_err",   32'(err_count),  32'd0);
      rstn = 1'b1;

      // 0xA5 with a spacer after each bit
      send_word(8'hA5, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1);
      chk("a5_valid_once", 32'(word_valid), 32'd0);
      chk("a5_hold",       32'(word_data),  32'hA5);
      chk("a5_model",      32'(m.word),     32'hA5);
      chk("a5_errs",       32'(err_count),  32'd0);

      // Codeword held for 4 cycles counts once
      drive(1'b1, 1'b0, 1'b0, 4);
      drive(1'b0, 1'b0, 1'b0, 1);
      chk("hold_cnt", 32'(bit_cnt), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 1);
      drive(1'b0, 1'b0, 1'b1, 1);

      // Partial word aborted by an illegal sample
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      drive(1'b1, 1'b1, 1'b0, 1);
      chk("abort_pulse", 32'(err_pulse), 32'd1);
      chk("abort_cnt",   32'(err_count), 32'd1);
      chk("abort_bits",  32'(bit_cnt),   32'd0);
      drive(1'b0, 1'b0, 1'b0, 1);
      chk("abort_pulse_end", 32'(err_pulse), 32'd0);
      send_word(8'h3C, 1'b1);
      chk("abort_data", 32'(word_data), 32'h3C);

      // Saturation of the 2-bit counter and clear-with-error
      drive(1'b0, 1'b0, 1'b1, 1);
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 1'b1, 1'b0, 1);
         chk("sat_cnt2", 32'(err_count2), 32'(exp5[k]));
         drive(1'b0, 1'b0, 1'b0, 1);
      end
      drive(1'b1, 1'b1, 1'b1, 1);
      chk("clr_err_same", 32'(err_count2), 32'd1);
      chk("clr_err_same8", 32'(err_count), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1);

      // Asynchronous reset mid-word, released while a codeword is present
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      chk("pre_rst_cnt", 32'(bit_cnt), 32'd5);
      #2 rstn = 1'b0;
      #1 chk("async_rst_cnt", 32'(bit_cnt), 32'd0);
      @(negedge clk);
      rail_t = 1'b0; rail_f = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 2);
      chk("rel_ignored", 32'(bit_cnt), 32'd0);
      send_word(8'hFF, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1);

      // Back-to-back words
      vt.delete();
      vd.delete();
      send_word(8'h01, 1'b0);
      send_word(8'h80, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1);
      chk("b2b_count", 32'(vt.size()), 32'd2);
      if (vt.size() == 2) begin
         chk("b2b_gap",   32'(vt[1] - vt[0]), 32'd16);
         chk("b2b_data0", 32'(vd[0]), 32'h01);
         chk("b2b_data1", 32'(vd[1]), 32'h80);
      end

      // Randomized traffic against the model
      for (int it = 0; it < 2500; it++) begin
         int r;
         int len;
         logic clr;
         r   = int'($urandom_range(0, 99));
         len = int'($urandom_range(1, 3));
         clr = ($urandom_range(0, 99) < 3);
         if (r < 40)      drive(1'b0, 1'b0, clr, len);
         else if (r < 65) drive(1'b1, 1'b0, clr, len);
         else if (r < 90) drive(1'b0, 1'b1, clr, len);
         else if (r < 99) drive(1'b1, 1'b1, clr, 1);
         else begin
            #2 rstn = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
         end
      end

      drive(1'b0, 1'b0, 1'b0, 2);
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
